// File: rtl/multi_stage_output_channel_occupancy_tracker.sv
// multi_stage_output_channel_occupancy_tracker: per-channel committed plus in-flight occupancy with projected-full flags.
// Defining TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN adds a sticky protocol-violation error output.
module multi_stage_output_channel_occupancy_tracker #(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int NUM_STAGES   = 2,
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1),
    localparam int PROJ_WIDTH  = COUNT_WIDTH + $clog2(NUM_STAGES + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  issue_valid,
    input  logic [NUM_CHANNELS-1:0]               issue_oci,
    input  logic                                  advance,
    input  logic                                  flush,
    input  logic [NUM_CHANNELS-1:0]               dequeue,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]   channel_counts,
    output logic [NUM_CHANNELS-1:0]               full_status
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
    ,
    output logic                                  error
`endif
);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(FIFO_DEPTH);

    logic [NUM_CHANNELS-1:0] stage [NUM_STAGES];
    logic [COUNT_WIDTH-1:0]  count [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]  count_next [NUM_CHANNELS];
    logic [PROJ_WIDTH-1:0]   projected [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] retire;

    // A same-cycle retire and dequeue cancel; out-of-range moves are absorbed at 0 and FIFO_DEPTH.
    always_comb begin
        retire = advance && !flush ? stage[NUM_STAGES-1] : '0;
        channel_counts = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            count_next[c] = retire[c] == dequeue[c] ? count[c] :
                            retire[c] ? (count[c] == MAX_COUNT ? count[c] : count[c] + COUNT_WIDTH'(1)) :
                            (count[c] == '0 ? count[c] : count[c] - COUNT_WIDTH'(1));
            projected[c] = PROJ_WIDTH'(count[c]);
            for (int s = 0; s < NUM_STAGES; s++)
                projected[c] = projected[c] + PROJ_WIDTH'(stage[s][c]);
            full_status[c] = projected[c] >= PROJ_WIDTH'(FIFO_DEPTH);
            channel_counts[c*COUNT_WIDTH +: COUNT_WIDTH] = count[c];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STAGES; s++) stage[s] <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) count[c] <= '0;
        end else begin
            if (flush) begin
                for (int s = 0; s < NUM_STAGES; s++) stage[s] <= '0;
            end else if (advance) begin
                stage[0] <= issue_valid ? issue_oci : '0;
                for (int s = 1; s < NUM_STAGES; s++) stage[s] <= stage[s-1];
            end
            for (int c = 0; c < NUM_CHANNELS; c++) count[c] <= count_next[c];
        end
    end

`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
    logic violation;

    always_comb begin
        violation = advance && issue_valid && |(issue_oci & full_status);
        for (int c = 0; c < NUM_CHANNELS; c++)
            violation = violation ||
                        (dequeue[c] && !retire[c] && count[c] == '0) ||
                        (retire[c] && !dequeue[c] && count[c] == MAX_COUNT);
    end

    always_ff @(posedge clock) begin
        if (!reset) error <= 1'b0;
        else error <= error || violation;
    end
`endif
endmodule

// File: tb/tb_multi_stage_output_channel_occupancy_tracker.sv
// tb_multi_stage_output_channel_occupancy_tracker: vector table plus directed reset/error sequences.
// Honours TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN to also check the error output.
module tb_multi_stage_output_channel_occupancy_tracker;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_oci = '0;
    logic        advance = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  dequeue = '0;
    logic [11:0] channel_counts;
    logic [3:0]  full_status;
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
    logic        error;
`endif

    multi_stage_output_channel_occupancy_tracker #(
        .NUM_CHANNELS(4), .FIFO_DEPTH(4), .NUM_STAGES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_oci(issue_oci),
        .advance(advance),
        .flush(flush),
        .dequeue(dequeue),
        .channel_counts(channel_counts),
        .full_status(full_status)
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        ,
        .error(error)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [3:0]  oci;
        logic        adv;
        logic        fl;
        logic [3:0]  deq;
        logic [11:0] cnt;
        logic [3:0]  full;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] cnt;
        logic [3:0]  full;
    } exp_t;

    exp_t sb[$];
    vec_t v[33];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        tests++;
        if (channel_counts !== e.cnt) begin
            fails++;
            $display("FAIL %s counts: got %h expected %h", e.name, channel_counts, e.cnt);
        end
        tests++;
        if (full_status !== e.full) begin
            fails++;
            $display("FAIL %s full: got %b expected %b", e.name, full_status, e.full);
        end
    endtask

    task automatic step(input logic rst_n, input logic iv, input logic [3:0] oci, input logic adv,
                        input logic fl, input logic [3:0] deq, input string name,
                        input logic [11:0] cnt, input logic [3:0] full);
        exp_t e;
        @(negedge clock);
        reset = rst_n;
        issue_valid = iv;
        issue_oci = oci;
        advance = adv;
        flush = fl;
        dequeue = deq;
        e.name = name;
        e.cnt = cnt;
        e.full = full;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check();
    endtask

`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
    task automatic check_err(input string name, input logic exp);
        tests++;
        if (error !== exp) begin
            fails++;
            $display("FAIL %s error: got %b expected %b", name, error, exp);
        end
    endtask
`endif

    initial begin
        v[0]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, pk(0,0,0,0), 4'b0000};
        v[1]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, pk(0,0,0,0), 4'b0000};
        v[2]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, pk(0,0,0,1), 4'b0000};
        v[3]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, pk(0,0,0,1), 4'b0000};
        v[4]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, pk(0,0,0,2), 4'b0001};
        v[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(0,0,0,3), 4'b0001};
        v[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(0,0,0,4), 4'b0001};
        v[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, pk(0,0,0,3), 4'b0000};
        v[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, pk(0,0,0,2), 4'b0000};
        v[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, pk(0,0,0,1), 4'b0000};
        v[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, pk(0,0,0,0), 4'b0000};
        v[11] = '{1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, pk(0,0,0,0), 4'b0000};
        v[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(0,0,0,0), 4'b0000};
        v[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(0,0,1,1), 4'b0000};
        v[14] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, pk(0,0,1,1), 4'b0000};
        v[15] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, pk(0,0,1,1), 4'b0000};
        v[16] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, pk(0,1,1,1), 4'b0000};
        v[17] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(0,2,1,1), 4'b0000};
        v[18] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, pk(0,2,1,1), 4'b0000};
        v[19] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, pk(0,2,1,1), 4'b0000};
        v[20] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, pk(0,2,1,1), 4'b0000};
        v[21] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, pk(1,2,1,1), 4'b0000};
        v[22] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, pk(2,2,1,1), 4'b1000};
        v[23] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, pk(3,2,1,1), 4'b1000};
        v[24] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(4,2,1,1), 4'b1000};
        v[25] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(4,2,1,1), 4'b1000};
        v[26] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b1101, pk(3,1,1,0), 4'b0000};
        v[27] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, pk(3,1,1,0), 4'b0000};
        v[28] = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, pk(3,1,1,0), 4'b0000};
        v[29] = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, pk(3,1,1,0), 4'b0000};
        v[30] = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, pk(3,1,2,0), 4'b0010};
        v[31] = '{1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, pk(3,1,2,0), 4'b0000};
        v[32] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, pk(3,1,2,0), 4'b0000};

        step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b1111, "reset0", pk(0,0,0,0), 4'b0000);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, "reset1", pk(0,0,0,0), 4'b0000);
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        check_err("reset_err", 1'b0);
`endif

        for (int i = 0; i < 33; i++)
            step(1'b1, v[i].iv, v[i].oci, v[i].adv, v[i].fl, v[i].deq,
                 $sformatf("row%0d", i), v[i].cnt, v[i].full);
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        check_err("table_err", 1'b1);
`endif

        // Mid-stream reset with two channel-0 entries in flight: nothing may retire afterwards.
        step(1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, "rs_fill0", pk(3,1,2,0), 4'b0000);
        step(1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, "rs_fill1", pk(3,1,2,0), 4'b0000);
        step(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, "rs_reset", pk(0,0,0,0), 4'b0000);
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        check_err("rs_err", 1'b0);
`endif
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000,
                 $sformatf("rs_adv%0d", i), pk(0,0,0,0), 4'b0000);

        // Dropped dequeue on channel 3 at zero, then sticky error cleared only by reset.
        step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, "drop_deq", pk(0,0,0,0), 4'b0000);
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        check_err("drop_err", 1'b1);
`endif
        step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, "drop_hold", pk(0,0,0,0), 4'b0000);
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        check_err("drop_sticky", 1'b1);
`endif
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, "drop_reset", pk(0,0,0,0), 4'b0000);
`ifdef TIA_OCCUPANCY_TRACKER_ERROR_CHECK_EN
        check_err("drop_clear", 1'b0);
`endif

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
